// File: rtl/morphle_pkg.sv
// morphle_pkg: register map, bit indices and loader FSM states shared by the yblock loader
package morphle_pkg;
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_CWORD   = 3'd2;
    localparam logic [2:0] REG_UIN     = 3'd3;
    localparam logic [2:0] REG_UOUT    = 3'd4;
    localparam logic [2:0] REG_CBITOUT = 3'd5;
    localparam int CTRL_MRST   = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;
    localparam int ST_BUSY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_DONE = 2;
    localparam int ST_OVF  = 3;
    typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} fsm_state_e;
endpackage

// File: rtl/morphle_wb_loader_if.sv
// morphle_wb_loader_if: Wishbone slave bus bundle for the yblock loader
interface morphle_wb_loader_if;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdat;
    modport master (output cyc, stb, we, sel, adr, wdat, input ack, rdat);
    modport slave (input cyc, stb, we, sel, adr, wdat, output ack, rdat);
endinterface

// File: rtl/morphle_cfg_fifo.sv
// morphle_cfg_fifo: synchronous configuration-word FIFO with flush
module morphle_cfg_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot, so a push to a full FIFO still lands
    assign do_push = push & (~full | do_pop);
    assign empty = wp == rp;
    assign full  = wp == {~rp[AW], rp[AW-1:0]};
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wp[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + {{AW{1'b0}}, 1'b1};
            if (do_pop) rp <= rp + {{AW{1'b0}}, 1'b1};
        end
endmodule

// File: rtl/morphle_wb_loader.sv
// morphle_wb_loader: Wishbone slave that serialises config words into a yblock
// cbitin column with generated confclk strobes, and exposes uin/uout/cbitout.
module morphle_wb_loader
    import morphle_pkg::*;
#(
    parameter int BLOCKWIDTH  = 16,
    parameter int BLOCKHEIGHT = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 2,
    parameter int HOLD_CYC    = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    morphle_wb_loader_if.slave      wbs,
    output logic                    mreset_o,
    output logic                    confclk_o,
    output logic [BLOCKWIDTH-1:0]   cbitin_o,
    input  logic [BLOCKWIDTH-1:0]   cbitout_i,
    output logic [2*BLOCKWIDTH-1:0] uin_o,
    input  logic [2*BLOCKWIDTH-1:0] uout_i,
    output logic                    irq_o
);
    localparam int UW = 2 * BLOCKWIDTH;
    fsm_state_e state;
    logic [7:0] ph, cnt;
    logic mrst, irq_en, done, ovf, busy;
    logic [UW-1:0] uin_r, uout_s1, uout_s2;
    logic [BLOCKWIDTH-1:0] cbit_s1, cbit_s2, cbitout_r, fifo_dout;
    logic fifo_full, fifo_empty;
    logic valid, acc, wr, wr_ctrl, wr_status, push, pop, abort, strobe_end, done_set;
    logic [2:0] a;
    logic [31:0] rdata, status;
    logic unused_adr;

    assign valid = wbs.cyc & wbs.stb;
    assign acc = valid & ~wbs.ack;
    assign wr = acc & wbs.we;
    assign a = wbs.adr[4:2];
    assign unused_adr = ^{wbs.adr[31:5], wbs.adr[1:0]};
    assign wr_ctrl = wr && a == REG_CTRL && wbs.sel[0];
    assign wr_status = wr && a == REG_STATUS && wbs.sel[0];
    assign push = wr && a == REG_CWORD && |wbs.sel;
    // MRST or FLUSH written high aborts the load and empties the FIFO next cycle
    assign abort = wr_ctrl && (wbs.wdat[CTRL_MRST] || wbs.wdat[CTRL_FLUSH]);
    assign strobe_end = state == HOLD && ph == 8'(HOLD_CYC - 1);
    assign pop = !abort && !mrst && !fifo_empty && (state == IDLE || strobe_end);
    assign done_set = !abort && strobe_end && cnt == 8'(BLOCKHEIGHT - 1);
    assign busy = state != IDLE || !fifo_empty;
    assign status = {16'd0, cnt, 4'd0, ovf, done, fifo_full, busy};
    assign rdata = a == REG_CTRL    ? {29'd0, 1'b0, irq_en, mrst} :
                   a == REG_STATUS  ? status :
                   a == REG_UIN     ? 32'(uin_r) :
                   a == REG_UOUT    ? 32'(uout_s2) :
                   a == REG_CBITOUT ? 32'(cbitout_r) : 32'd0;
    assign mreset_o = mrst;
    assign uin_o = uin_r;
    assign irq_o = done & irq_en;

    morphle_cfg_fifo #(.WIDTH(BLOCKWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(wb_clk_i), .rst_n(wb_rst_ni), .flush(abort), .push(push), .pop(pop),
        .din(wbs.wdat[BLOCKWIDTH-1:0]), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            wbs.ack <= 1'b0;
            wbs.rdat <= '0;
            mrst <= 1'b1;
            irq_en <= 1'b0;
            done <= 1'b0;
            ovf <= 1'b0;
            uin_r <= '0;
        end else begin
            wbs.ack <= acc;
            wbs.rdat <= acc ? rdata : '0;
            if (wr_ctrl) begin
                mrst <= wbs.wdat[CTRL_MRST];
                irq_en <= wbs.wdat[CTRL_IRQ_EN];
            end
            done <= done_set | (done & ~(wr_status & wbs.wdat[ST_DONE]));
            ovf <= (push & fifo_full & ~pop) | (ovf & ~(wr_status & wbs.wdat[ST_OVF]));
            if (wr && a == REG_UIN)
                for (int i = 0; i < UW; i++)
                    if (wbs.sel[i/8]) uin_r[i] <= wbs.wdat[i];
        end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            uout_s1 <= '0;
            uout_s2 <= '0;
            cbit_s1 <= '0;
            cbit_s2 <= '0;
            cbitout_r <= '0;
        end else begin
            uout_s1 <= uout_i;
            uout_s2 <= uout_s1;
            cbit_s1 <= cbitout_i;
            cbit_s2 <= cbit_s1;
            if (state == HOLD && ph == 8'd0) cbitout_r <= cbit_s2;
        end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            state <= IDLE;
            ph <= '0;
            cnt <= '0;
            confclk_o <= 1'b0;
            cbitin_o <= '0;
        end else if (abort) begin
            state <= IDLE;
            ph <= '0;
            cnt <= '0;
            confclk_o <= 1'b0;
        end else begin
            if (pop) cbitin_o <= fifo_dout;
            case (state)
                IDLE: if (pop) begin
                    state <= SETUP;
                    ph <= '0;
                end
                SETUP: if (ph == 8'(SETUP_CYC - 1)) begin
                    state <= HIGH;
                    ph <= '0;
                    confclk_o <= 1'b1;
                end else ph <= ph + 8'd1;
                HIGH: if (ph == 8'(PULSE_CYC - 1)) begin
                    state <= HOLD;
                    ph <= '0;
                    confclk_o <= 1'b0;
                end else ph <= ph + 8'd1;
                HOLD: if (strobe_end) begin
                    state <= pop ? SETUP : IDLE;
                    ph <= '0;
                    cnt <= done_set ? 8'd0 : cnt + 8'd1;
                end else ph <= ph + 8'd1;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_morphle_wb_loader.sv
// tb_morphle_wb_loader: directed-vector bench for the Wishbone yblock loader
module tb_morphle_wb_loader;
    import morphle_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mreset, confclk, irq;
    logic [15:0] cbitin;
    logic [15:0] cbitout = '0;
    logic [31:0] uin;
    logic [31:0] uout = '0;
    int nvec = 0;
    int nerr = 0;
    int pulses = 0;
    time rise_t = 0;
    time last_w = 0;
    time ack_t = 0;

    morphle_wb_loader_if bus();

    morphle_wb_loader dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(bus),
        .mreset_o(mreset), .confclk_o(confclk), .cbitin_o(cbitin), .cbitout_i(cbitout),
        .uin_o(uin), .uout_i(uout), .irq_o(irq)
    );

    always #5 clk = ~clk;

    always @(posedge confclk) begin
        pulses++;
        rise_t = $time;
    end

    always @(negedge confclk) last_w = $time - rise_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [2:0] r, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
        int n = 0;
        @(negedge clk);
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we = w;
        bus.adr = {27'd0, r, 2'b00};
        bus.wdat = d;
        bus.sel = s;
        do begin
            @(posedge clk);
            ack_t = $time;
            #1;
            n++;
        end while (!bus.ack && n < 10);
        if (!bus.ack) chk("ack_timeout", 32'(bus.ack), 32'd1);
        q = bus.rdat;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, r, d, 4'hf, q);
    endtask

    task automatic rd(input logic [2:0] r, output logic [31:0] q);
        wb_xfer(1'b0, r, 32'd0, 4'hf, q);
    endtask

    task automatic wait_idle();
        logic [31:0] q;
        int n = 0;
        do begin
            rd(REG_STATUS, q);
            n++;
        end while (q[ST_BUSY] && n < 200);
        if (q[ST_BUSY]) chk("idle_timeout", q, 32'd0);
    endtask

    initial begin
        logic [31:0] q;
        int p0, n;
        time tw;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we = 1'b0;
        bus.sel = 4'h0;
        bus.adr = '0;
        bus.wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mreset", 32'(mreset), 32'd1);
        chk("rst_confclk", 32'(confclk), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_cbitin", 32'(cbitin), 32'd0);
        chk("rst_uin", uin, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        rd(REG_CTRL, q);
        chk("ctrl_rst", q, 32'h1);
        rd(REG_STATUS, q);
        chk("status_rst", q, 32'h0);

        wr(REG_CTRL, 32'h0);
        chk("mreset_clr", 32'(mreset), 32'd0);
        p0 = pulses;
        wr(REG_CWORD, 32'hA5C3);
        tw = ack_t;
        wait_idle();
        chk("single_pulses", pulses - p0, 32'd1);
        chk("single_width", 32'(last_w / 10), 32'd2);
        chk("single_rise_lat", 32'((rise_t - tw) / 10), 32'd2);
        chk("single_cbitin", 32'(cbitin), 32'hA5C3);
        rd(REG_STATUS, q);
        chk("single_status", q, 32'h0100);

        wr(REG_CTRL, 32'h6);
        p0 = pulses;
        for (int i = 1; i <= 16; i++) begin
            n = 0;
            do begin
                rd(REG_STATUS, q);
                n++;
            end while (q[ST_FULL] && n < 50);
            wr(REG_CWORD, 32'(i));
        end
        wait_idle();
        chk("load_pulses", pulses - p0, 32'd16);
        chk("load_cbitin", 32'(cbitin), 32'h0010);
        rd(REG_STATUS, q);
        chk("load_status", q, 32'h0004);
        chk("load_irq", 32'(irq), 32'd1);
        wr(REG_STATUS, 32'h4);
        rd(REG_STATUS, q);
        chk("done_w1c", q, 32'h0);
        chk("irq_w1c", 32'(irq), 32'd0);

        wr(REG_CTRL, 32'h3);
        p0 = pulses;
        for (int i = 0; i < 5; i++) wr(REG_CWORD, 32'h11 + 32'(i));
        repeat (10) @(posedge clk);
        #1;
        chk("ovf_no_pulse", pulses - p0, 32'd0);
        chk("ovf_mreset", 32'(mreset), 32'd1);
        rd(REG_STATUS, q);
        chk("ovf_status", q, 32'h000B);
        wr(REG_CTRL, 32'h2);
        wait_idle();
        chk("ovf_pulses", pulses - p0, 32'd4);
        chk("ovf_cbitin", 32'(cbitin), 32'h0014);
        rd(REG_STATUS, q);
        chk("ovf_status2", q, 32'h0408);
        wr(REG_STATUS, 32'h8);
        rd(REG_STATUS, q);
        chk("ovf_w1c", q, 32'h0400);

        p0 = pulses;
        for (int i = 0; i < 4; i++) wr(REG_CWORD, 32'h21 + 32'(i));
        n = 0;
        while (pulses - p0 < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reach", pulses - p0, 32'd3);
        chk("abort_in_high", 32'(confclk), 32'd1);
        wr(REG_CTRL, 32'h1);
        chk("abort_confclk", 32'(confclk), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_pulses", pulses - p0, 32'd3);
        chk("abort_mreset", 32'(mreset), 32'd1);
        rd(REG_STATUS, q);
        chk("abort_status", q, 32'h0);

        wr(REG_CTRL, 32'h0);
        @(negedge clk) uout = 32'hDEADBEEF;
        rd(REG_UOUT, q);
        chk("uout_early", q, 32'h0);
        rd(REG_UOUT, q);
        chk("uout", q, 32'hDEADBEEF);
        wr(REG_UIN, 32'h12345678);
        chk("uin_out", uin, 32'h12345678);
        wb_xfer(1'b1, REG_UIN, 32'hFFFFFFFF, 4'b0001, q);
        chk("uin_sel", uin, 32'h123456FF);
        rd(REG_UIN, q);
        chk("uin_read", q, 32'h123456FF);
        cbitout = 16'h00FF;
        repeat (3) @(posedge clk);
        wr(REG_CWORD, 32'h5A5A);
        wait_idle();
        chk("cbit_cbitin", 32'(cbitin), 32'h5A5A);
        rd(REG_CBITOUT, q);
        chk("cbitout", q, 32'h00FF);
        rd(REG_STATUS, q);
        chk("final_status", q, 32'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
